debouncer_multi: RTL and testbench
==================================

DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent button channels (>=1).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per channel (>=2).
REQ-003 Parameter STABLE_CYC, default 50000, consecutive cycles a new input level must hold before acceptance (>=1).
REQ-004 Parameter LONG_CYC, default 50000000, cycles of accepted press before long-press event (>=1).
REQ-005 Parameter CNT_W, default 26, counter width; SHALL satisfy 2^CNT_W > max(STABLE_CYC, LONG_CYC).
REQ-006 Parameter ACTIVE_LOW, default 1, 1 = pin low means pressed.
REQ-007 clk  input  1  single system clock, all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 btn  input  N_CH  raw asynchronous button pins, one bit per channel.
REQ-010 level  output  N_CH  debounced pressed state (1 = pressed).
REQ-011 press  output  N_CH  one-cycle pulse on accepted press.
REQ-012 release  output  N_CH  one-cycle pulse on accepted release.
REQ-013 toggle  output  N_CH  state flipped on every accepted press.
REQ-014 long_press  output  N_CH  one-cycle pulse when press held LONG_CYC cycles.

Function
REQ-015 Channels SHALL be fully independent; no shared counters or state.
REQ-016 Each btn bit SHALL pass through SYNC_STAGES flops; raw_pressed = synchroniser output XOR ACTIVE_LOW.
REQ-017 Per-channel FSM states: IDLE (level=0), PRESS_WAIT, HELD (level=1), RELEASE_WAIT.
REQ-018 IDLE -> PRESS_WAIT when raw_pressed=1; stable counter cleared.
REQ-019 PRESS_WAIT: raw_pressed=1 increments counter; raw_pressed=0 returns to IDLE, counter cleared; no outputs change.
REQ-020 PRESS_WAIT -> HELD on the edge where raw_pressed has been 1 for STABLE_CYC consecutive cycles (counting the IDLE exit cycle); same edge: level<=1, press<=1 for one cycle, toggle inverted, hold counter cleared.
REQ-021 HELD -> RELEASE_WAIT when raw_pressed=0; mirror of REQ-019/020 back to IDLE with level<=0, release<=1 for one cycle.
REQ-022 RELEASE_WAIT with raw_pressed=1 returns to HELD; level stays 1, hold counter NOT cleared, no press pulse.
REQ-023 Hold counter increments each cycle in HELD or RELEASE_WAIT, saturates at LONG_CYC; long_press pulses once on the edge it reaches LONG_CYC; no repeat until level has returned to 0.
REQ-024 Latency pin-to-level: SYNC_STAGES + STABLE_CYC cycles for a clean edge; a glitch shorter than STABLE_CYC cycles SHALL produce no output activity.
REQ-025 Counters SHALL never wrap; press, release, long_press are never asserted simultaneously on one channel except long_press with nothing else.
REQ-026 STABLE_CYC=1: level follows synchronised input with one extra cycle; FSM rules unchanged.

Reset
REQ-027 rst=0 SHALL immediately force: synchronisers to released pin level, FSM IDLE, counters 0, level=0, press=0, release=0, toggle=0, long_press=0.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard progress; after release of rst, a held button is re-qualified from IDLE (full SYNC_STAGES+STABLE_CYC latency, press pulse issued).

Verification (N_CH=2, SYNC_STAGES=2, STABLE_CYC=4, LONG_CYC=10, ACTIVE_LOW=1)
REQ-029 btn[0] 1->0 held -> level[0]=1 and press[0] one cycle exactly 6 cycles after pin edge; toggle[0] 0->1; channel 1 outputs stay 0.
REQ-030 btn[0] low pulses of 1,2,3 cycles separated by 2 high cycles -> level, press, toggle unchanged throughout.
REQ-031 Press held 20 cycles after acceptance -> long_press[0] single pulse 10 cycles after press pulse; no second pulse; release -> release[0] pulse 6 cycles after pin rises.
REQ-032 Release bounce of 2 cycles inside HELD, then held low -> no release pulse, long_press timing unaffected.
REQ-033 Both channels pressed same cycle, three full press/release cycles -> identical simultaneous pulses; toggle ends 1 on both.
REQ-034 rst pulled low during PRESS_WAIT and during HELD with btn held low -> all outputs 0 asynchronously; after rst=1, press re-issued 6 cycles later.

Source files
------------

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel button debouncer with press/release/toggle/long-press events
//
// Ports:
//   clk           in   1     system clock, all state on the rising edge
//   rst           in   1     asynchronous active-low reset
//   btn           in   N_CH  raw asynchronous button pins, one per channel
//   level         out  N_CH  debounced pressed state (1 = pressed)
//   press         out  N_CH  one-cycle pulse on an accepted press
//   release_pulse out  N_CH  one-cycle pulse on an accepted release
//   toggle        out  N_CH  flips on every accepted press
//   long_press    out  N_CH  one-cycle pulse once a press has been held LONG_CYC cycles
//
// Every channel owns its synchroniser, FSM and counters; nothing is shared.

module debouncer_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 50000,
    parameter int LONG_CYC    = 50000000,
    parameter int CNT_W       = 26,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] toggle,
    output logic [N_CH-1:0] long_press
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // Pin level when the button is not pressed; synchronisers reset to it so
    // that leaving reset never looks like an edge.
    localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

    // The cycle that leaves IDLE (or HELD) already counts as the first stable
    // cycle, and the stable counter is cleared on that edge. The wait state
    // therefore accepts once the counter has reached STABLE_CYC-2.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'((STABLE_CYC >= 2) ? STABLE_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] LONG_LIM    = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    // With a single-cycle stability window the wait states are skipped.
    localparam logic SINGLE = (STABLE_CYC <= 1);

    genvar ch;
    generate
        for (ch = 0; ch < N_CH; ch++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   raw_pressed;

            state_t           state_q, state_d;
            logic [CNT_W-1:0] stable_q, stable_d;
            logic [CNT_W-1:0] hold_q, hold_d;
            logic             level_q, level_d;
            logic             press_q, press_d;
            logic             rel_q, rel_d;
            logic             tog_q, tog_d;
            logic             long_q, long_d;

            // Input synchroniser, bit 0 is the first stage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= {SYNC_STAGES{PIN_IDLE}};
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], btn[ch]};
                end
            end

            assign raw_pressed = sync_q[SYNC_STAGES-1] ^ PIN_IDLE;

            always_comb begin
                state_d  = state_q;
                stable_d = stable_q;
                hold_d   = hold_q;
                level_d  = level_q;
                press_d  = 1'b0;
                rel_d    = 1'b0;
                tog_d    = tog_q;
                long_d   = 1'b0;

                // Hold counter runs while the debounced level is high and
                // stops at LONG_CYC, so the long-press pulse fires only once
                // per press. The release-accept branch below overrides it.
                if ((state_q == HELD || state_q == RELEASE_WAIT) && hold_q != LONG_LIM) begin
                    hold_d = hold_q + ONE;
                    if (hold_q + ONE == LONG_LIM) begin
                        long_d = 1'b1;
                    end
                end

                case (state_q)
                    IDLE: begin
                        if (raw_pressed) begin
                            stable_d = '0;
                            if (SINGLE) begin
                                state_d = HELD;
                                level_d = 1'b1;
                                press_d = 1'b1;
                                tog_d   = ~tog_q;
                                hold_d  = '0;
                            end else begin
                                state_d = PRESS_WAIT;
                            end
                        end
                    end

                    PRESS_WAIT: begin
                        if (!raw_pressed) begin
                            state_d  = IDLE;
                            stable_d = '0;
                        end else if (stable_q >= STABLE_LAST) begin
                            state_d  = HELD;
                            stable_d = '0;
                            level_d  = 1'b1;
                            press_d  = 1'b1;
                            tog_d    = ~tog_q;
                            hold_d   = '0;
                        end else begin
                            stable_d = stable_q + ONE;
                        end
                    end

                    HELD: begin
                        if (!raw_pressed) begin
                            stable_d = '0;
                            if (SINGLE) begin
                                state_d = IDLE;
                                level_d = 1'b0;
                                rel_d   = 1'b1;
                                hold_d  = '0;
                                long_d  = 1'b0;
                            end else begin
                                state_d = RELEASE_WAIT;
                            end
                        end
                    end

                    RELEASE_WAIT: begin
                        if (raw_pressed) begin
                            // Bounce inside a hold: keep the hold count going.
                            state_d  = HELD;
                            stable_d = '0;
                        end else if (stable_q >= STABLE_LAST) begin
                            state_d  = IDLE;
                            stable_d = '0;
                            level_d  = 1'b0;
                            rel_d    = 1'b1;
                            hold_d   = '0;
                            long_d   = 1'b0;
                        end else begin
                            stable_d = stable_q + ONE;
                        end
                    end

                    default: begin
                        state_d  = IDLE;
                        stable_d = '0;
                        hold_d   = '0;
                        level_d  = 1'b0;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q  <= IDLE;
                    stable_q <= '0;
                    hold_q   <= '0;
                    level_q  <= 1'b0;
                    press_q  <= 1'b0;
                    rel_q    <= 1'b0;
                    tog_q    <= 1'b0;
                    long_q   <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    stable_q <= stable_d;
                    hold_q   <= hold_d;
                    level_q  <= level_d;
                    press_q  <= press_d;
                    rel_q    <= rel_d;
                    tog_q    <= tog_d;
                    long_q   <= long_d;
                end
            end

            assign level[ch]         = level_q;
            assign press[ch]         = press_q;
            assign release_pulse[ch] = rel_q;
            assign toggle[ch]        = tog_q;
            assign long_press[ch]    = long_q;
        end
    endgenerate

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - self-checking bench for debouncer_multi

module tb_debouncer_multi;

    localparam int N_CH   = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int LONG   = 10;
    localparam int CNT_W  = 8;
    localparam int TBL_N  = 36;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] btn = 2'b11;
    logic [N_CH-1:0] level, press, release_pulse, toggle, long_press;

    always #5 clk = ~clk;

    debouncer_multi #(
        .N_CH       (N_CH),
        .SYNC_STAGES(SYNC),
        .STABLE_CYC (STABLE),
        .LONG_CYC   (LONG),
        .CNT_W      (CNT_W),
        .ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .toggle       (toggle),
        .long_press   (long_press)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pin samples are delayed SYNC edges, then a channel's
    // level flips once the last STABLE raw samples all disagree with it.
    // A long press is the edge exactly LONG edges after the press edge while
    // the level is still high.
    logic [N_CH-1:0] pin_q[$];
    logic [N_CH-1:0] raw_q[$];
    logic [N_CH-1:0] m_level, m_press, m_rel, m_tog, m_long;
    int              t_now;
    int              acc_t[N_CH];

    typedef struct {
        logic [1:0] btn;
        logic [9:0] exp;
    } vec_t;
    vec_t tbl[TBL_N];

    function automatic logic [9:0] outs();
        return {level, press, release_pulse, toggle, long_press};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        pin_q.delete();
        for (int i = 0; i < SYNC; i++) pin_q.push_back(2'b11);
        raw_q.delete();
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        m_tog   = '0;
        m_long  = '0;
        t_now   = 0;
        foreach (acc_t[c]) acc_t[c] = 0;
    endtask

    task automatic model_edge();
        logic [N_CH-1:0] raw;
        logic            flip;
        raw = ~pin_q.pop_front();
        pin_q.push_back(btn);
        raw_q.push_back(raw);
        if (raw_q.size() > STABLE) void'(raw_q.pop_front());
        t_now++;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        for (int c = 0; c < N_CH; c++) begin
            flip = (raw_q.size() == STABLE);
            foreach (raw_q[i]) if (raw_q[i][c] == m_level[c]) flip = 1'b0;
            if (flip) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) begin
                    m_press[c] = 1'b1;
                    m_tog[c]   = ~m_tog[c];
                    acc_t[c]   = t_now;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end else if (m_level[c] && (t_now - acc_t[c] == LONG)) begin
                m_long[c] = 1'b1;
            end
        end
    endtask

    // One clock: model advances on the edge, outputs compared half a cycle later.
    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        check("model", 32'(outs()), 32'({m_level, m_press, m_rel, m_tog, m_long}));
    endtask

    // Called at a falling edge; reset lands mid-cycle and must clear at once.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("reset_async", 32'(outs()), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic press_latency(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (press[0]) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog @%0t: simulation did not finish", $time);
        $fatal(1);
    end

    initial begin
        int lat;
        int first_long, n_long, n_rel, np0, np1;

        for (int k = 0; k < TBL_N; k++) begin
            int  s;
            logic lv, pr, rl, tg, lg;
            s  = k + 1;
            lv = (s >= 6) && (s < 32);
            pr = (s == 6);
            rl = (s == 32);
            tg = (s >= 6);
            lg = (s == 16);
            tbl[k].btn = (s <= 26) ? 2'b10 : 2'b11;
            tbl[k].exp = {1'b0, lv, 1'b0, pr, 1'b0, rl, 1'b0, tg, 1'b0, lg};
        end

        model_reset();
        #2;
        rst = 1'b0;
        #1;
        check("reset_init", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Clean press on channel 0, long hold, clean release.
        for (int k = 0; k < TBL_N; k++) begin
            btn = tbl[k].btn;
            step();
            check("table", 32'(outs()), 32'(tbl[k].exp));
        end

        // Short low glitches must be invisible.
        do_reset();
        btn = 2'b11;
        step();
        step();
        for (int w = 1; w <= 3; w++) begin
            btn[0] = 1'b0;
            for (int i = 0; i < w; i++) begin
                step();
                check("glitch", 32'({level[0], press[0], toggle[0], release_pulse[0]}), 32'd0);
            end
            btn[0] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                step();
                check("glitch", 32'({level[0], press[0], toggle[0], release_pulse[0]}), 32'd0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check("glitch", 32'({level[0], press[0], toggle[0], release_pulse[0]}), 32'd0);
        end

        // Release bounce while held: no release, long press still on time.
        do_reset();
        btn = 2'b10;
        press_latency(lat);
        check("bounce_press_lat", 32'(lat), 32'd6);
        first_long = 0;
        n_long     = 0;
        n_rel      = 0;
        for (int i = 1; i <= 20; i++) begin
            btn[0] = (i == 4 || i == 5) ? 1'b1 : 1'b0;
            step();
            if (long_press[0]) begin
                n_long++;
                if (first_long == 0) first_long = i;
            end
            if (release_pulse[0]) n_rel++;
        end
        check("bounce_long_at", 32'(first_long), 32'd10);
        check("bounce_long_cnt", 32'(n_long), 32'd1);
        check("bounce_no_release", 32'(n_rel), 32'd0);
        check("bounce_level", 32'(level[0]), 32'd1);
        btn = 2'b11;
        for (int i = 0; i < 8; i++) step();

        // Both channels together, three full cycles.
        do_reset();
        np0 = 0;
        np1 = 0;
        for (int r = 0; r < 3; r++) begin
            btn = 2'b00;
            for (int i = 0; i < 12; i++) begin
                step();
                if (press[0]) np0++;
                if (press[1]) np1++;
            end
            btn = 2'b11;
            for (int i = 0; i < 8; i++) step();
        end
        check("dual_press0", 32'(np0), 32'd3);
        check("dual_press1", 32'(np1), 32'd3);
        check("dual_toggle", 32'(toggle), 32'd3);

        // Reset during PRESS_WAIT, then during HELD, with the button held.
        do_reset();
        btn = 2'b10;
        for (int i = 0; i < 4; i++) step();
        do_reset();
        press_latency(lat);
        check("rst_pw_latency", 32'(lat), 32'd6);
        for (int i = 0; i < 5; i++) step();
        check("held_before_rst", 32'({level[0], toggle[0]}), 32'd3);
        do_reset();
        press_latency(lat);
        check("rst_held_latency", 32'(lat), 32'd6);
        check("rst_held_toggle", 32'(toggle), 32'd1);

        // Random pin activity against the reference model.
        btn = 2'b11;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
